// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, decode result and the bundle
// handed from decode/issue to the ALU execute stage.
package mips_pkg;

    localparam int DATA_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_MUL   = 6'h3E;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef struct packed {
        logic [5:0]        opcode;
        logic [5:0]        alu_control;
        logic [4:0]        shamt;
        logic [15:0]       immediate;
        logic [DATA_W-1:0] rs_content;
        logic [DATA_W-1:0] rt_content;
        logic [4:0]        dest;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } ex_bundle_t;

    typedef struct packed {
        logic       legal;
        logic       uses_rt;
        logic [4:0] dest;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [5:0] alu_control;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t       d;
        logic [5:0] op;
        logic [5:0] fn;
        op = instr[31:26];
        fn = instr[5:0];
        d  = '0;
        unique case (op)
            OP_RTYPE: begin
                d.uses_rt     = 1'b1;
                d.dest        = instr[15:11];
                d.alu_control = fn;
                unique case (fn)
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_NOR, FN_SLT: d.legal = 1'b1;
                    default: d.legal = 1'b0;
                endcase
            end
            OP_MUL: begin
                d.legal   = 1'b1;
                d.uses_rt = 1'b1;
                d.dest    = instr[15:11];
            end
            OP_ADDI, OP_ADDIU: begin
                d.legal = 1'b1;
                d.dest  = instr[20:16];
            end
            OP_LW: begin
                d.legal    = 1'b1;
                d.dest     = instr[20:16];
                d.mem_read = 1'b1;
            end
            OP_SW: begin
                d.legal     = 1'b1;
                d.uses_rt   = 1'b1;
                d.mem_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                d.legal   = 1'b1;
                d.uses_rt = 1'b1;
            end
            default: d.legal = 1'b0;
        endcase
        // r0 as destination never produces a write or a scoreboard entry
        d.reg_write = d.legal && (d.dest != 5'd0);
        return d;
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 2R/1W register file, r0 hardwired to zero,
// same-cycle write data bypassed into both read ports.
module mips_regfile #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   i_raddr_a,
    input  logic [AW-1:0]   i_raddr_b,
    output logic [XLEN-1:0] o_rdata_a,
    output logic [XLEN-1:0] o_rdata_b,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata
);

    logic [XLEN-1:0] r_mem [NREGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata_a = r_mem[i_raddr_a];
        if (i_raddr_a == '0) begin
            o_rdata_a = '0;
        end else if (i_we && (i_waddr == i_raddr_a)) begin
            o_rdata_a = i_wdata;
        end
    end

    always_comb begin
        o_rdata_b = r_mem[i_raddr_b];
        if (i_raddr_b == '0) begin
            o_rdata_b = '0;
        end else if (i_we && (i_waddr == i_raddr_b)) begin
            o_rdata_b = i_wdata;
        end
    end

endmodule

// File: rtl/mips_decode_issue.sv
// mips_decode_issue: decode, operand read, scoreboard hazard check
// and a held output bundle for the ALU execute stage.
module mips_decode_issue
    import mips_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    output logic            if_ready,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [5:0]      ex_opcode,
    output logic [5:0]      ex_alu_control,
    output logic [4:0]      ex_shamt,
    output logic [15:0]     ex_immediate,
    output logic [XLEN-1:0] ex_rs_content,
    output logic [XLEN-1:0] ex_rt_content,
    output logic [4:0]      ex_dest,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            illegal
);

    logic [4:0]       w_rs;
    logic [4:0]       w_rt;
    dec_t             w_dec;
    logic [XLEN-1:0]  w_rs_data;
    logic [XLEN-1:0]  w_rt_data;
    logic             w_clr_rs;
    logic             w_clr_rt;
    logic             w_hazard;
    logic             w_accept;
    logic [NREGS-1:0] w_busy_nxt;
    ex_bundle_t       w_bundle;

    logic [NREGS-1:0] r_busy;
    ex_bundle_t       r_ex;
    logic             r_ex_valid;
    logic             r_illegal;

    assign w_rs  = if_instr[25:21];
    assign w_rt  = if_instr[20:16];
    assign w_dec = decode(if_instr);

    mips_regfile #(
        .NREGS (NREGS),
        .XLEN  (XLEN),
        .AW    (5)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_raddr_a (w_rs),
        .i_raddr_b (w_rt),
        .o_rdata_a (w_rs_data),
        .o_rdata_b (w_rt_data),
        .i_we      (wb_en),
        .i_waddr   (wb_addr),
        .i_wdata   (wb_data)
    );

    // A source retiring this cycle is already bypassed by the regfile
    assign w_clr_rs = wb_en && (wb_addr == w_rs);
    assign w_clr_rt = wb_en && (wb_addr == w_rt);

    assign w_hazard = w_dec.legal &&
                      ((r_busy[w_rs] && !w_clr_rs) ||
                       (w_dec.uses_rt && r_busy[w_rt] && !w_clr_rt) ||
                       r_busy[w_dec.dest]);

    assign if_ready = !w_hazard && (!r_ex_valid || ex_ready) && !flush;
    assign w_accept = if_valid && if_ready;

    always_comb begin
        w_bundle             = '0;
        w_bundle.opcode      = if_instr[31:26];
        w_bundle.alu_control = w_dec.alu_control;
        w_bundle.shamt       = if_instr[10:6];
        w_bundle.immediate   = if_instr[15:0];
        w_bundle.rs_content  = w_rs_data;
        w_bundle.rt_content  = w_rt_data;
        w_bundle.dest        = w_dec.dest;
        w_bundle.reg_write   = w_dec.reg_write;
        w_bundle.mem_read    = w_dec.mem_read;
        w_bundle.mem_write   = w_dec.mem_write;
    end

    // Clears first, so a set on the same register wins
    always_comb begin
        w_busy_nxt = r_busy;
        if (flush && r_ex_valid && r_ex.reg_write) begin
            w_busy_nxt[r_ex.dest] = 1'b0;
        end
        if (wb_en) begin
            w_busy_nxt[wb_addr] = 1'b0;
        end
        if (w_accept && w_dec.reg_write) begin
            w_busy_nxt[w_dec.dest] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_ex       <= '0;
            r_ex_valid <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_illegal <= w_accept && !w_dec.legal;
            if (flush) begin
                r_ex_valid <= 1'b0;
            end else if (w_accept) begin
                r_ex_valid <= w_dec.legal;
                if (w_dec.legal) begin
                    r_ex <= w_bundle;
                end
            end else if (ex_ready) begin
                r_ex_valid <= 1'b0;
            end
        end
    end

    assign ex_valid       = r_ex_valid;
    assign ex_opcode      = r_ex.opcode;
    assign ex_alu_control = r_ex.alu_control;
    assign ex_shamt       = r_ex.shamt;
    assign ex_immediate   = r_ex.immediate;
    assign ex_rs_content  = r_ex.rs_content;
    assign ex_rt_content  = r_ex.rt_content;
    assign ex_dest        = r_ex.dest;
    assign ex_reg_write   = r_ex.reg_write;
    assign ex_mem_read    = r_ex.mem_read;
    assign ex_mem_write   = r_ex.mem_write;
    assign illegal        = r_illegal;

endmodule

// File: tb/tb_mips_decode_issue.sv
// tb_mips_decode_issue: directed scenarios plus random traffic
// compared every cycle against a behavioural model.
module tb_mips_decode_issue;

    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [5:0]  ex_opcode;
    logic [5:0]  ex_alu_control;
    logic [4:0]  ex_shamt;
    logic [15:0] ex_immediate;
    logic [31:0] ex_rs_content;
    logic [31:0] ex_rt_content;
    logic [4:0]  ex_dest;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        illegal;

    mips_decode_issue #(.NREGS(32), .XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_ready       (if_ready),
        .wb_en          (wb_en),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_opcode      (ex_opcode),
        .ex_alu_control (ex_alu_control),
        .ex_shamt       (ex_shamt),
        .ex_immediate   (ex_immediate),
        .ex_rs_content  (ex_rs_content),
        .ex_rt_content  (ex_rt_content),
        .ex_dest        (ex_dest),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .illegal        (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    logic        m_ev;
    logic        m_ill;
    logic [5:0]  e_op, e_alu;
    logic [4:0]  e_sh, e_dst;
    logic [15:0] e_imm;
    logic [31:0] e_rs, e_rt;
    logic        e_rw, e_mr, e_mw;
    logic        last_ready;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void mdec(input logic [31:0] ins, output logic lg,
                                 output logic urt, output logic [4:0] dst);
        logic [5:0] op;
        logic [5:0] fn;
        op  = ins[31:26];
        fn  = ins[5:0];
        lg  = 1'b0;
        urt = 1'b0;
        dst = 5'd0;
        case (op)
            6'h00: begin
                lg  = fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A};
                urt = 1'b1;
                dst = ins[15:11];
            end
            6'h3E: begin lg = 1'b1; urt = 1'b1; dst = ins[15:11]; end
            6'h08, 6'h09, 6'h23: begin lg = 1'b1; dst = ins[20:16]; end
            6'h2B, 6'h04, 6'h05: begin lg = 1'b1; urt = 1'b1; end
            default: lg = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rdval(input logic [4:0] a, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return m_regs[a];
    endfunction

    task automatic step(input logic rst, input logic v, input logic [31:0] ins,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic er, input logic fl);
        logic        lg, urt, haz, rdy, acc;
        logic [4:0]  dst, rs, rt;
        logic [31:0] rsv, rtv, nb;
        rst_n    = !rst;
        if_valid = v;
        if_instr = ins;
        wb_en    = we;
        wb_addr  = wa;
        wb_data  = wd;
        ex_ready = er;
        flush    = fl;
        #1;
        last_ready = if_ready;
        rs = ins[25:21];
        rt = ins[20:16];
        mdec(ins, lg, urt, dst);
        haz = lg && ((m_busy[rs] && !(we && wa == rs)) ||
                     (urt && m_busy[rt] && !(we && wa == rt)) ||
                     m_busy[dst]);
        rdy = !haz && (!m_ev || er) && !fl;
        if (!rst && v) chk("if_ready", 32'(if_ready), 32'(rdy));
        acc = v && rdy;
        rsv = rdval(rs, we, wa, wd);
        rtv = rdval(rt, we, wa, wd);
        if (rst) begin
            for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
            m_busy = 32'd0;
            m_ev   = 1'b0;
            m_ill  = 1'b0;
            {e_op, e_alu, e_sh, e_dst, e_imm, e_rs, e_rt, e_rw, e_mr, e_mw} = '0;
        end else begin
            nb = m_busy;
            if (fl && m_ev && e_rw) nb[e_dst] = 1'b0;
            if (we) nb[wa] = 1'b0;
            if (acc && lg && dst != 5'd0) nb[dst] = 1'b1;
            m_busy = nb;
            if (we && wa != 5'd0) m_regs[wa] = wd;
            m_ill = acc && !lg;
            if (fl) begin
                m_ev = 1'b0;
            end else if (acc) begin
                m_ev = lg;
                if (lg) begin
                    e_op  = ins[31:26];
                    e_alu = (ins[31:26] == 6'h00) ? ins[5:0] : 6'd0;
                    e_sh  = ins[10:6];
                    e_imm = ins[15:0];
                    e_rs  = rsv;
                    e_rt  = rtv;
                    e_dst = dst;
                    e_rw  = (dst != 5'd0);
                    e_mr  = (ins[31:26] == 6'h23);
                    e_mw  = (ins[31:26] == 6'h2B);
                end
            end else if (er) begin
                m_ev = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("ex_valid", 32'(ex_valid), 32'(m_ev));
        chk("illegal", 32'(illegal), 32'(m_ill));
        if (m_ev) begin
            chk("ex_opcode", 32'(ex_opcode), 32'(e_op));
            chk("ex_alu_control", 32'(ex_alu_control), 32'(e_alu));
            chk("ex_shamt", 32'(ex_shamt), 32'(e_sh));
            chk("ex_immediate", 32'(ex_immediate), 32'(e_imm));
            chk("ex_rs_content", ex_rs_content, e_rs);
            chk("ex_rt_content", ex_rt_content, e_rt);
            chk("ex_dest", 32'(ex_dest), 32'(e_dst));
            chk("ex_reg_write", 32'(ex_reg_write), 32'(e_rw));
            chk("ex_mem_read", 32'(ex_mem_read), 32'(e_mr));
            chk("ex_mem_write", 32'(ex_mem_write), 32'(e_mw));
        end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [5:0]  fns [8];
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A};
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        sh  = 5'($urandom);
        imm = 16'($urandom);
        case ($urandom_range(0, 10))
            0, 1: return {6'h00, rs, rt, rd, sh, fns[$urandom_range(0, 7)]};
            2:    return {6'h00, rs, rt, rd, sh, 6'h00};
            3:    return {6'h3E, rs, rt, rd, sh, 6'h00};
            4:    return {6'h08, rs, rt, imm};
            5:    return {6'h09, rs, rt, imm};
            6:    return {6'h23, rs, rt, imm};
            7:    return {6'h2B, rs, rt, imm};
            8:    return {6'h04, rs, rt, imm};
            9:    return {6'h05, rs, rt, imm};
            default: return {6'h3F, rs, rt, imm};
        endcase
    endfunction

    initial begin
        logic [4:0] wa;
        m_busy = '0;
        m_ev   = 1'b0;
        m_ill  = 1'b0;
        e_rw   = 1'b0;
        e_dst  = '0;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_ex_valid", 32'(ex_valid), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_opcode", 32'(ex_opcode), 0);
        chk("rst_imm", 32'(ex_immediate), 0);
        chk("rst_rs", ex_rs_content, 0);
        chk("rst_dest", 32'(ex_dest), 0);
        chk("rst_reg_write", 32'(ex_reg_write), 0);

        step(0, 1, 32'h20010005, 0, 0, 0, 1, 0);
        chk("addi_valid", 32'(ex_valid), 1);
        chk("addi_opcode", 32'(ex_opcode), 32'h08);
        chk("addi_imm", 32'(ex_immediate), 32'h5);
        chk("addi_rs", ex_rs_content, 0);
        chk("addi_dest", 32'(ex_dest), 1);

        step(0, 1, 32'h00211020, 0, 0, 0, 1, 0);
        chk("raw_stall", 32'(last_ready), 0);
        step(0, 1, 32'h00211020, 1, 5'd1, 32'd5, 1, 0);
        chk("raw_release", 32'(last_ready), 1);
        chk("raw_rs", ex_rs_content, 5);
        chk("raw_rt", ex_rt_content, 5);
        chk("raw_alu", 32'(ex_alu_control), 32'h20);

        for (int i = 0; i < 3; i++) begin
            step(0, 1, 32'h20050009, 0, 0, 0, 0, 0);
            chk("bp_stall", 32'(last_ready), 0);
            chk("bp_hold_rs", ex_rs_content, 5);
            chk("bp_hold_dest", 32'(ex_dest), 2);
        end
        step(0, 1, 32'h20050009, 0, 0, 0, 1, 0);
        chk("bp_accept", 32'(last_ready), 1);
        chk("bp_next_dest", 32'(ex_dest), 5);

        step(0, 1, 32'h8C030000, 0, 0, 0, 1, 0);
        chk("lw_mem_read", 32'(ex_mem_read), 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("flush_valid", 32'(ex_valid), 0);
        step(0, 1, 32'h00602020, 0, 0, 0, 1, 0);
        chk("flush_no_stall", 32'(last_ready), 1);

        step(0, 1, 32'h20000007, 0, 0, 0, 1, 0);
        chk("r0_valid", 32'(ex_valid), 1);
        chk("r0_reg_write", 32'(ex_reg_write), 0);
        step(0, 1, 32'hFC000000, 0, 0, 0, 1, 0);
        chk("ill_pulse", 32'(illegal), 1);
        chk("ill_no_bundle", 32'(ex_valid), 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        chk("ill_one_cycle", 32'(illegal), 0);

        for (int c = 0; c < 3000; c++) begin
            if (c == 1500 || c == 1501) begin
                step(1, 1, gen_instr(), 0, 0, 0, 1, 0);
            end else begin
                wa = 5'($urandom_range(0, 7));
                for (int k = 1; k < 32; k++) begin
                    if (m_busy[k] && $urandom_range(0, 1) == 1) wa = 5'(k);
                end
                step(0,
                     $urandom_range(0, 4) != 0,
                     gen_instr(),
                     $urandom_range(0, 2) != 0,
                     wa,
                     $urandom,
                     $urandom_range(0, 3) != 0,
                     $urandom_range(0, 9) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_decode_issue.md
# mips_decode_issue

Decode/issue stage that produces the operand and control bundle consumed by the 32-bit ALU. It accepts fetched instruction words over a valid/ready handshake, splits the fields and reads a 32×32 register file. It tracks pending register writes with a scoreboard and stalls on hazards. It holds the issued bundle in an output register until the execute stage accepts it.

## Interface
- `NREGS`, 32: register count; `r0` is hardwired to zero.
- `XLEN`, 32: datapath width.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `if_valid` in 1: instruction word offered.
- `if_instr` in 32: instruction word.
- `if_ready` out 1: instruction accepted this cycle when `if_valid & if_ready`.
- `wb_en` in 1: register write-back strobe.
- `wb_addr` in 5: write-back register index.
- `wb_data` in 32: write-back data.
- `flush` in 1: branch taken; discard the held bundle.
- `ex_valid` out 1: bundle valid.
- `ex_ready` in 1: execute stage accepts the bundle.
- `ex_opcode` out 6: instruction bits [31:26].
- `ex_alu_control` out 6: funct field for R-type, 0 otherwise.
- `ex_shamt` out 5: instruction bits [10:6].
- `ex_immediate` out 16: instruction bits [15:0].
- `ex_rs_content` out 32: rs operand.
- `ex_rt_content` out 32: rt operand.
- `ex_dest` out 5: destination register, 0 if none.
- `ex_reg_write` out 1: instruction writes a register.
- `ex_mem_read` out 1: instruction is lw.
- `ex_mem_write` out 1: instruction is sw.
- `illegal` out 1: one-cycle pulse when an unsupported encoding is consumed.

## Operation
- **Supported R-type** (opcode 0x00), by funct: 0x20, 0x21, 0x22, 0x23, 0x24, 0x25, 0x27, 0x2a. Destination is rd.
- **Supported other opcodes:**
  - 0x3E mul: reads rs and rt, destination rd.
  - 0x08 addi, 0x09 addiu: destination rt.
  - 0x23 lw: destination rt.
  - 0x2B sw: reads rt, no destination.
  - 0x04 beq, 0x05 bne: read rt, no destination.
- **Source usage:** rs is read by every instruction. rt is read by R-type, mul, sw, beq and bne.
- **Destination 0:** a destination of register 0 forces `ex_reg_write = 0`.
- **Register file:**
  - Reads are combinational at decode.
  - A same-cycle write-back to the register being read bypasses `wb_data` into the read.
  - Writes to `r0` are ignored.
- **Scoreboard:** one busy bit per register.
  - Set when an instruction with `ex_reg_write = 1` is loaded into the output register.
  - Cleared on `wb_en` for `wb_addr`.
- **Hazard** when any of these holds; `if_ready` is low while it holds:
  - a used source register is busy and is not being cleared by write-back this cycle;
  - the destination register is busy (WAW).
- **Issue:** `if_ready = !hazard & (!ex_valid | ex_ready) & !flush`.
- **Illegal encoding:** consumed normally, no bundle issued, no scoreboard change, `illegal` pulses for one cycle.
- **Flush:**
  - Clears `ex_valid`.
  - Clears the busy bit of the flushed bundle's destination if `ex_reg_write` was set.
  - No instruction is accepted in a flush cycle.
- **Simultaneous set and clear** of the same busy bit: set wins.
- **Reset:**
  - Clears the register file, the scoreboard, `ex_valid`, `illegal` and every `ex_*` output to 0.
  - Reset mid-operation discards the held bundle.

## Timing
- Latency: `ex_valid` rises the cycle after the `if` handshake.
- Full throughput, one instruction per cycle, when there are no hazards and `ex_ready` is high.
- Bundle stability: while `ex_valid & !ex_ready`, all `ex_*` outputs hold their values.
- `illegal` is registered and asserts the cycle after the handshake.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants: `OP_RTYPE`, `OP_ADDI`, `OP_ADDIU`, `OP_BEQ`, `OP_BNE`, `OP_LW`, `OP_SW`, `OP_MUL`;
  - funct constants;
  - a bundle struct for the `ex_*` fields.
- One sub-module, `mips_regfile`: 2 read ports, 1 write port, write-through bypass, synchronous clear.

## Test plan
- **Reset then addi:** reset, then `addi r1,r0,5` (0x20010005) → next cycle `ex_valid=1`, `ex_opcode=0x08`, `ex_immediate=0x0005`, `ex_rs_content=0`, `ex_dest=1`.
- **RAW stall and release:** issue `addi r1`, then `add r2,r1,r1` → `if_ready=0` until `wb_en`, `wb_addr=1`, `wb_data=5`. In that same cycle `if_ready=1`; the bundle carries rs=rt=5 and `ex_alu_control=0x20`.
- **Backpressure:** hold `ex_ready=0` for 3 cycles with a bundle held → `ex_*` outputs are unchanged and `if_ready=0`. Raising `ex_ready` accepts the next instruction the same cycle.
- **Flush:** `flush` while an `lw r3` bundle is held → `ex_valid=0` next cycle, the r3 busy bit is cleared, and a following `add r4,r3,r0` issues without stall.
- **r0 and illegal:** `addi r0,r0,7` → `ex_reg_write=0`, no scoreboard bit set. Opcode 0x3F → `illegal=1` for one cycle and `ex_valid` stays 0.
